// File: rtl/led_seq_if.sv
// Front-panel bus of the LED sequencer: raw buttons and rate tick in,
// rate-counter configuration word, LED pattern and mode out.
interface led_seq_if #(
    parameter int NB_LEDS = 4,
    parameter int NB_BTN  = 3
);
    logic [NB_BTN-1:0]  i_btn;
    logic               i_valid;
    logic [2:0]         o_sw;
    logic [NB_LEDS-1:0] o_led;
    logic [1:0]         o_mode;

    // Driver side (board buttons / rate counter)
    modport master (
        output i_btn,
        output i_valid,
        input  o_sw,
        input  o_led,
        input  o_mode
    );

    // Controller side
    modport slave (
        input  i_btn,
        input  i_valid,
        output o_sw,
        output o_led,
        output o_mode
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED sequencer front-panel controller: synchronizes push buttons into
// run/rate/mode press events and steps a rotate-left / rotate-right / flash
// pattern on each rising edge of the rate counter tick while running.
module led_seq_ctrl #(
    parameter int NB_LEDS = 4,
    parameter int NB_BTN  = 3
) (
    input  logic      clock,
    input  logic      i_reset,
    led_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_SHL   = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_FLASH = 2'b10
    } mode_e;

    localparam int BTN_RUN  = 0;
    localparam int BTN_RATE = 1;
    localparam int BTN_MODE = 2;

    logic [NB_BTN-1:0]  sync1_q, sync1_d;
    logic [NB_BTN-1:0]  sync2_q, sync2_d;
    logic [NB_BTN-1:0]  hist_q,  hist_d;
    logic [NB_BTN-1:0]  ev_q,    ev_d;
    logic               vld_dly_q, vld_dly_d;
    logic               run_q,   run_d;
    logic [1:0]         rate_q,  rate_d;
    mode_e              mode_q,  mode_d;
    logic [NB_LEDS-1:0] led_q,   led_d;
    logic               step;

    // Pattern loaded when a mode is entered
    function automatic logic [NB_LEDS-1:0] seed(input mode_e m);
        case (m)
            MODE_SHL: seed = {{(NB_LEDS-1){1'b0}}, 1'b1};
            MODE_SHR: seed = {1'b1, {(NB_LEDS-1){1'b0}}};
            default:  seed = '0;
        endcase
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_SHL: next_mode = MODE_SHR;
            MODE_SHR: next_mode = MODE_FLASH;
            default:  next_mode = MODE_SHL;
        endcase
    endfunction

    // Next-state: button event pipeline, config registers, mode FSM and pattern step
    always_comb begin
        sync1_d   = bus.i_btn;
        sync2_d   = sync1_q;
        hist_d    = sync2_q;
        // Registered so config changes land three edges after first sampling
        ev_d      = sync2_q & ~hist_q;
        vld_dly_d = bus.i_valid;
        // Only a fresh rising tick counts; a stuck-high tick from a disabled counter is ignored
        step      = bus.i_valid & ~vld_dly_q & run_q;

        run_d  = run_q ^ ev_q[BTN_RUN];
        rate_d = rate_q + {1'b0, ev_q[BTN_RATE]};
        mode_d = mode_q;
        led_d  = led_q;

        // A mode change overrides a coincident step: the new seed is shown unrotated
        if (ev_q[BTN_MODE]) begin
            mode_d = next_mode(mode_q);
            led_d  = seed(mode_d);
        end else if (step) begin
            case (mode_q)
                MODE_SHL: led_d = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
                MODE_SHR: led_d = {led_q[0], led_q[NB_LEDS-1:1]};
                default:  led_d = ~led_q;
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (i_reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            hist_q    <= '0;
            ev_q      <= '0;
            vld_dly_q <= 1'b0;
            run_q     <= 1'b0;
            rate_q    <= 2'b00;
            mode_q    <= MODE_SHL;
            led_q     <= seed(MODE_SHL);
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            hist_q    <= hist_d;
            ev_q      <= ev_d;
            vld_dly_q <= vld_dly_d;
            run_q     <= run_d;
            rate_q    <= rate_d;
            mode_q    <= mode_d;
            led_q     <= led_d;
        end
    end

    assign bus.o_sw   = {rate_q, run_q};
    assign bus.o_mode = mode_q;
    assign bus.o_led  = led_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with NB_LEDS=4: reset, run/rate/mode
// buttons, pattern stepping, mode/step collision, stop/resume and mid-run reset.
module tb_led_seq_ctrl;

    logic clock;
    logic i_reset;
    int   errors = 0;
    int   checks = 0;

    led_seq_if #(.NB_LEDS(4), .NB_BTN(3)) bus ();

    led_seq_ctrl #(.NB_LEDS(4), .NB_BTN(3)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One-cycle tick, then idle so the next tick is every 8 cycles
    task automatic pulse();
        bus.i_valid = 1'b1;
        @(negedge clock);
        bus.i_valid = 1'b0;
        repeat (7) @(negedge clock);
    endtask

    // Press and release a button, long enough for the event to be applied
    task automatic press(input int b);
        bus.i_btn[b] = 1'b1;
        repeat (6) @(negedge clock);
        bus.i_btn[b] = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.o_sw !== 3'b000) begin errors++; $display("FAIL reset_sw got=%b exp=%b", bus.o_sw, 3'b000); end
        checks++;
        if (bus.o_mode !== 2'b00) begin errors++; $display("FAIL reset_mode got=%b exp=%b", bus.o_mode, 2'b00); end
        checks++;
        if (bus.o_led !== 4'b0001) begin errors++; $display("FAIL reset_led got=%b exp=%b", bus.o_led, 4'b0001); end
        i_reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 20; i++) begin
            pulse();
            checks++;
            if (bus.o_led !== 4'b0001) begin errors++; $display("FAIL stopped_led[%0d] got=%b exp=%b", i, bus.o_led, 4'b0001); end
        end
        checks++;
        if (bus.o_sw !== 3'b000) begin errors++; $display("FAIL stopped_sw got=%b exp=%b", bus.o_sw, 3'b000); end
    endtask

    task automatic test_run();
        logic [3:0] exp_led [5];
        exp_led = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        bus.i_btn[0] = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.o_sw !== 3'b000) begin errors++; $display("FAIL run_edge_k2 got=%b exp=%b", bus.o_sw, 3'b000); end
        @(negedge clock);
        checks++;
        if (bus.o_sw !== 3'b001) begin errors++; $display("FAIL run_edge_k3 got=%b exp=%b", bus.o_sw, 3'b001); end
        bus.i_btn[0] = 1'b0;
        repeat (6) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            pulse();
            checks++;
            if (bus.o_led !== exp_led[i]) begin errors++; $display("FAIL shl_step[%0d] got=%b exp=%b", i, bus.o_led, exp_led[i]); end
        end
    endtask

    task automatic test_rate();
        logic [1:0] exp_rate [5];
        exp_rate = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        for (int i = 0; i < 5; i++) begin
            press(1);
            checks++;
            if (bus.o_sw !== {exp_rate[i], 1'b1}) begin errors++; $display("FAIL rate_step[%0d] got=%b exp=%b", i, bus.o_sw, {exp_rate[i], 1'b1}); end
        end
        bus.i_btn[1] = 1'b1;
        repeat (50) @(negedge clock);
        bus.i_btn[1] = 1'b0;
        repeat (6) @(negedge clock);
        checks++;
        if (bus.o_sw !== 3'b101) begin errors++; $display("FAIL rate_hold got=%b exp=%b", bus.o_sw, 3'b101); end
    endtask

    task automatic test_mode();
        press(2);
        checks++;
        if (bus.o_mode !== 2'b01 || bus.o_led !== 4'b1000) begin errors++; $display("FAIL mode_shr got=%b/%b exp=01/1000", bus.o_mode, bus.o_led); end
        pulse();
        checks++;
        if (bus.o_led !== 4'b0100) begin errors++; $display("FAIL shr_step0 got=%b exp=%b", bus.o_led, 4'b0100); end
        pulse();
        checks++;
        if (bus.o_led !== 4'b0010) begin errors++; $display("FAIL shr_step1 got=%b exp=%b", bus.o_led, 4'b0010); end
        press(2);
        checks++;
        if (bus.o_mode !== 2'b10 || bus.o_led !== 4'b0000) begin errors++; $display("FAIL mode_flash got=%b/%b exp=10/0000", bus.o_mode, bus.o_led); end
        pulse();
        checks++;
        if (bus.o_led !== 4'b1111) begin errors++; $display("FAIL flash_step0 got=%b exp=%b", bus.o_led, 4'b1111); end
        pulse();
        checks++;
        if (bus.o_led !== 4'b0000) begin errors++; $display("FAIL flash_step1 got=%b exp=%b", bus.o_led, 4'b0000); end
        press(2);
        checks++;
        if (bus.o_mode !== 2'b00 || bus.o_led !== 4'b0001) begin errors++; $display("FAIL mode_shl got=%b/%b exp=00/0001", bus.o_mode, bus.o_led); end
    endtask

    task automatic test_coincident();
        pulse();
        pulse();
        checks++;
        if (bus.o_led !== 4'b0100) begin errors++; $display("FAIL coin_setup got=%b exp=%b", bus.o_led, 4'b0100); end
        bus.i_btn[2] = 1'b1;
        repeat (3) @(negedge clock);
        bus.i_valid = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.o_mode !== 2'b01 || bus.o_led !== 4'b1000) begin errors++; $display("FAIL coin_seed got=%b/%b exp=01/1000", bus.o_mode, bus.o_led); end
        bus.i_valid = 1'b0;
        bus.i_btn[2] = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic test_stop_resume();
        bus.i_valid = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.o_led !== 4'b0100) begin errors++; $display("FAIL stop_pre_step got=%b exp=%b", bus.o_led, 4'b0100); end
        press(0);
        checks++;
        if (bus.o_sw !== 3'b100) begin errors++; $display("FAIL stop_sw got=%b exp=%b", bus.o_sw, 3'b100); end
        press(1);
        checks++;
        if (bus.o_sw !== 3'b110) begin errors++; $display("FAIL stopped_rate got=%b exp=%b", bus.o_sw, 3'b110); end
        press(0);
        checks++;
        if (bus.o_sw !== 3'b111) begin errors++; $display("FAIL resume_sw got=%b exp=%b", bus.o_sw, 3'b111); end
        checks++;
        if (bus.o_led !== 4'b0100) begin errors++; $display("FAIL resume_no_step got=%b exp=%b", bus.o_led, 4'b0100); end
        bus.i_valid = 1'b0;
        @(negedge clock);
        bus.i_valid = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.o_led !== 4'b0010) begin errors++; $display("FAIL resume_step got=%b exp=%b", bus.o_led, 4'b0010); end
        repeat (3) @(negedge clock);
        checks++;
        if (bus.o_led !== 4'b0010) begin errors++; $display("FAIL resume_single got=%b exp=%b", bus.o_led, 4'b0010); end
        bus.i_valid = 1'b0;
        repeat (7) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        pulse();
        checks++;
        if (bus.o_led !== 4'b0001) begin errors++; $display("FAIL mid_setup got=%b exp=%b", bus.o_led, 4'b0001); end
        bus.i_valid = 1'b1;
        bus.i_btn   = 3'b111;
        i_reset     = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.o_sw !== 3'b000 || bus.o_mode !== 2'b00 || bus.o_led !== 4'b0001) begin
            errors++;
            $display("FAIL mid_reset got=%b/%b/%b exp=000/00/0001", bus.o_sw, bus.o_mode, bus.o_led);
        end
        bus.i_valid = 1'b0;
        bus.i_btn   = 3'b000;
        repeat (4) @(negedge clock);
        i_reset = 1'b0;
        @(negedge clock);
        pulse();
        checks++;
        if (bus.o_led !== 4'b0001 || bus.o_sw !== 3'b000) begin errors++; $display("FAIL post_reset got=%b/%b exp=0001/000", bus.o_led, bus.o_sw); end
    endtask

    initial begin
        i_reset     = 1'b1;
        bus.i_btn   = 3'b000;
        bus.i_valid = 1'b0;
        test_reset();
        test_run();
        test_rate();
        test_mode();
        test_coincident();
        test_stop_resume();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
